// File: rtl/sto_pkg.sv
// sto_pkg: definitions shared by the sto load-stage blocks (sequencer, act and
// weight loaders).
//   sto_state_e      sequencer FSM state encoding
//   DEF_ACT_BEATS    activation beats delivered to the PE array per tile
//   DEF_DRAIN_CYC    systolic flush window after the stream, PE_ROWS+PE_COLS-1
//   DEF_TIMEOUT      maximum cycles spent waiting on a loader before giving up
package sto_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_LOAD   = 3'd1,
    A_STREAM = 3'd2,
    DRAIN    = 3'd3,
    ERR      = 3'd4,
    FIN      = 3'd5
  } sto_state_e;

  localparam int DEF_ACT_BEATS = 64;
  localparam int DEF_DRAIN_CYC = 31;
  localparam int DEF_TIMEOUT   = 4096;

endpackage

// File: rtl/sto_seq_if.sv
// sto_seq_if: host and loader handshake bundle of the sto tile sequencer.
//   Host side   : start, abort, num_tiles -> ; <- busy, done, tile_idx,
//                 err_timeout, err_beats
//   Loader side : <- weight_start, act_start ; weight_done, act_done,
//                 act_pe_valid ->
// Modports:
//   slave  - the sequencer itself
//   master - whoever drives the sequencer (host plus loaders, or a bench)
interface sto_seq_if #(
  parameter int TILE_W = 8
) ();

  logic              start;
  logic              abort;
  logic [TILE_W-1:0] num_tiles;
  logic              busy;
  logic              done;
  logic [TILE_W-1:0] tile_idx;
  logic              weight_start;
  logic              weight_done;
  logic              act_start;
  logic              act_done;
  logic              act_pe_valid;
  logic              err_timeout;
  logic              err_beats;

  modport slave (
    input  start, abort, num_tiles, weight_done, act_done, act_pe_valid,
    output busy, done, tile_idx, weight_start, act_start, err_timeout, err_beats
  );

  modport master (
    output start, abort, num_tiles, weight_done, act_done, act_pe_valid,
    input  busy, done, tile_idx, weight_start, act_start, err_timeout, err_beats
  );

endinterface

// File: rtl/sto_seq.sv
// sto_seq: tile sequencer in front of the sto load stage.
// For each of num_tiles tiles: pulse weight_start, wait for weight_done, pulse
// act_start, count act_pe_valid beats until act_done, then hold DRAIN_CYC
// cycles so the systolic skew flushes. A watchdog bounds both loader waits.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    sto_seq_if.slave (host controls/status and loader handshakes)
module sto_seq
  import sto_pkg::*;
#(
  parameter int TILE_W    = 8,
  parameter int ACT_BEATS = DEF_ACT_BEATS,
  parameter int BEAT_W    = 10,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic     clk,
  input logic     rst_n,
  sto_seq_if.slave bus
);

  // One counter serves as the watchdog in W_LOAD/A_STREAM and as the drain
  // timer in DRAIN, so it must hold the larger of the two limits.
  localparam int WAIT_MAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = {BEAT_W{1'b1}};

  sto_state_e        state_q, state_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_beats_q, err_beats_d;

  logic              first_cyc;
  logic [BEAT_W-1:0] beat_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tile_idx_q    <= '0;
      num_tiles_q   <= '0;
      beat_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_beats_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tile_idx_q    <= tile_idx_d;
      num_tiles_q   <= num_tiles_d;
      beat_cnt_q    <= beat_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_beats_q   <= err_beats_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    tile_idx_d    = tile_idx_q;
    num_tiles_d   = num_tiles_q;
    beat_cnt_d    = beat_cnt_q;
    wait_cnt_d    = wait_cnt_q + 1'b1;
    err_timeout_d = err_timeout_q;
    err_beats_d   = err_beats_q;

    // wait_cnt is zeroed on every entry to W_LOAD/A_STREAM/DRAIN, so zero marks
    // the first cycle of a state (start pulse cycle, done not yet honoured).
    first_cyc = (wait_cnt_q == '0);
    // The act_done cycle's own beat is part of the final count.
    beat_sum  = (beat_cnt_q == BEAT_MAX) ? beat_cnt_q
                                         : beat_cnt_q + BEAT_W'(bus.act_pe_valid);

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (bus.start) begin
          num_tiles_d   = bus.num_tiles;
          tile_idx_d    = '0;
          err_timeout_d = 1'b0;
          err_beats_d   = 1'b0;
          state_d       = (bus.num_tiles != '0) ? W_LOAD : FIN;
        end
      end
      W_LOAD: begin
        if (!first_cyc && bus.weight_done) begin
          state_d    = A_STREAM;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ERR;
        end
      end
      A_STREAM: begin
        beat_cnt_d = beat_sum;
        if (!first_cyc && bus.act_done) begin
          state_d    = DRAIN;
          wait_cnt_d = '0;
          if (beat_sum != BEAT_W'(ACT_BEATS)) err_beats_d = 1'b1;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ERR;
        end
      end
      DRAIN: begin
        if (wait_cnt_q == WAIT_W'(DRAIN_CYC - 1)) begin
          wait_cnt_d = '0;
          if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
            state_d = FIN;
          end else begin
            tile_idx_d = tile_idx_q + TILE_W'(1);
            state_d    = W_LOAD;
          end
        end
      end
      ERR: begin
        wait_cnt_d = '0;
        state_d    = FIN;
      end
      FIN: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase

    // Abort overrides everything, including a start seen in IDLE; the sticky
    // error flags survive so the host can still inspect them.
    if (bus.abort) begin
      state_d       = IDLE;
      tile_idx_d    = tile_idx_q;
      num_tiles_d   = num_tiles_q;
      beat_cnt_d    = beat_cnt_q;
      wait_cnt_d    = '0;
      err_timeout_d = err_timeout_q;
      err_beats_d   = err_beats_q;
    end
  end

  // Outputs; the pulses are masked by abort so an aborted cycle emits nothing.
  always_comb begin
    bus.busy         = (state_q != IDLE);
    bus.done         = (state_q == FIN) && !bus.abort;
    bus.weight_start = (state_q == W_LOAD) && first_cyc && !bus.abort;
    bus.act_start    = (state_q == A_STREAM) && first_cyc && !bus.abort;
    bus.tile_idx     = tile_idx_q;
    bus.err_timeout  = err_timeout_q;
    bus.err_beats    = err_beats_q;
  end

endmodule

// File: tb/tb_sto_seq.sv
// tb_sto_seq: randomized bench for sto_seq. The stimulus side plays host and
// both loaders; for each run it pushes the expected outcome (pulse counts,
// error flags, run length in busy cycles, final tile index) into a queue. An
// independent monitor watches the DUT every cycle and pops/compares at done.
module tb_sto_seq;

  localparam int TILE_W    = 8;
  localparam int N_BEATS   = 64;
  localparam int N_DRAIN   = 31;
  localparam int N_TIMEOUT = 4096;
  localparam int WAIT_LIM  = 6000;

  typedef struct {
    int w_pulses;
    int a_pulses;
    bit e_beats;
    bit e_to;
    int busy_len;
    int last_idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sto_seq_if #(.TILE_W(TILE_W)) bus ();

  sto_seq #(.TILE_W(TILE_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void check(string nm, longint act, longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  // ---------------- monitor ----------------
  bit   mon_prev_busy = 1'b0;
  int   mon_w = 0, mon_a = 0, mon_blen = 0, mon_last_ws = 0, mon_cyc = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst_n) begin
        mon_prev_busy = 1'b0;
        mon_w = 0; mon_a = 0; mon_blen = 0;
      end else begin
        if (bus.busy && !mon_prev_busy) begin
          check("err_beats_clear_on_start", bus.err_beats, 0);
          check("err_timeout_clear_on_start", bus.err_timeout, 0);
        end
        if (bus.busy) mon_blen++;
        if (bus.weight_start) begin
          check("weight_start_tile_idx", bus.tile_idx, mon_w);
          if (mon_w > 0) check("weight_start_gap_ge_drain", (mon_cyc - mon_last_ws) >= N_DRAIN, 1);
          mon_w++;
          mon_last_ws = mon_cyc;
        end
        if (bus.act_start) begin
          check("act_start_tile_idx", bus.tile_idx, mon_w - 1);
          mon_a++;
        end
        if (bus.done) begin
          check("done_with_busy", bus.busy, 1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", mon_cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("weight_start_count", mon_w, mon_e.w_pulses);
            check("act_start_count", mon_a, mon_e.a_pulses);
            check("err_beats", bus.err_beats, mon_e.e_beats);
            check("err_timeout", bus.err_timeout, mon_e.e_to);
            check("busy_cycles", mon_blen, mon_e.busy_len);
            check("final_tile_idx", bus.tile_idx, mon_e.last_idx);
          end
          mon_w = 0; mon_a = 0; mon_blen = 0;
        end else if (!bus.busy) begin
          mon_w = 0; mon_a = 0; mon_blen = 0;
        end
        mon_prev_busy = bus.busy;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // which: 0 weight_start, 1 act_start, 2 busy low
  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIM; c++) begin
      @(negedge clk);
      if ((which == 0 && bus.weight_start) || (which == 1 && bus.act_start) ||
          (which == 2 && !bus.busy)) begin
        ok = 1'b1;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_timeout: event %0d not seen within %0d cycles", which, WAIT_LIM);
  endtask

  task automatic serve_tile(input int wd, input int beats, input int gap_every,
                            input bit coinc, output bit ok);
    wait_for(0, ok);
    if (!ok) return;
    repeat (wd) @(posedge clk);
    #1 bus.weight_done = 1'b1;
    @(posedge clk);
    #1 bus.weight_done = 1'b0;
    wait_for(1, ok);
    if (!ok) return;
    for (int i = 0; i < beats; i++) begin
      @(posedge clk);
      #1;
      bus.act_pe_valid = 1'b1;
      bus.act_done     = coinc && (i == beats - 1);
      if (gap_every != 0 && (i + 1) % gap_every == 0 && i != beats - 1) begin
        @(posedge clk);
        #1;
        bus.act_pe_valid = 1'b0;
        bus.act_done     = 1'b0;
      end
    end
    if (!coinc) begin
      @(posedge clk);
      #1;
      bus.act_pe_valid = 1'b0;
      bus.act_done     = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.act_pe_valid = 1'b0;
    bus.act_done     = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.num_tiles = TILE_W'(n);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.num_tiles = TILE_W'($urandom);  // must have been latched already
  endtask

  // mode: 0 random, 1 fixed (weight_done @+5, 64 back-to-back beats), 2 random with tile 0 short
  task automatic do_run(input int n, input int mode);
    int   wd[8], bt[8], ge[8];
    bit   co[8];
    int   blen, idle, slen, r;
    bit   bad, ok;
    exp_t e;
    blen = 1;  // FIN cycle
    bad  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) begin
        wd[i] = 5; bt[i] = N_BEATS; ge[i] = 0; co[i] = 1'b0;
      end else begin
        wd[i] = $urandom_range(1, 6);
        r     = $urandom_range(0, 7);
        bt[i] = (r == 0) ? N_BEATS - 1 : (r == 1) ? N_BEATS + 1 : N_BEATS;
        if (mode == 2 && i == 0) bt[i] = N_BEATS - 1;
        ge[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 20);
        co[i] = 1'($urandom_range(0, 1));
      end
      idle = (ge[i] != 0) ? (bt[i] - 1) / ge[i] : 0;
      slen = bt[i] + idle + (co[i] ? 0 : 1);
      // W_LOAD: pulse cycle .. weight_done cycle; A_STREAM: act_start .. act_done
      blen += (wd[i] + 1) + (slen + 1) + N_DRAIN;
      if (bt[i] != N_BEATS) bad = 1'b1;
    end
    e = '{w_pulses: n, a_pulses: n, e_beats: bad, e_to: 1'b0,
          busy_len: blen, last_idx: (n == 0) ? 0 : n - 1};
    exp_q.push_back(e);
    pulse_start(n);
    for (int i = 0; i < n; i++) begin
      serve_tile(wd[i], bt[i], ge[i], co[i], ok);
      if (!ok) return;
    end
    wait_for(2, ok);
  endtask

  // ---------------- main sequence ----------------
  bit ok_m;
  int busy_seen;

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_tiles = '0;
    bus.weight_done = 1'b0; bus.act_done = 1'b0; bus.act_pe_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tile_idx", bus.tile_idx, 0);
    check("rst_weight_start", bus.weight_start, 0);
    check("rst_act_start", bus.act_start, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_err_beats", bus.err_beats, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_run(1, 1);                         // single tile, fixed timing
    do_run(3, 0);                         // three tiles
    do_run(0, 0);                         // empty run: FIN only
    do_run(1, 2);                         // short stream -> err_beats
    do_run(1, 1);                         // next start clears it
    for (int k = 0; k < 8; k++) do_run($urandom_range(1, 4), 0);

    // weight loader never answers -> watchdog
    exp_q.push_back('{w_pulses: 1, a_pulses: 0, e_beats: 1'b0, e_to: 1'b1,
                      busy_len: N_TIMEOUT + 2, last_idx: 0});
    pulse_start($urandom_range(1, 4));
    wait_for(2, ok_m);

    // abort in tile 1's stream, after tile 0 flagged a beat error;
    // a start while busy is ignored
    pulse_start(2);
    serve_tile(2, N_BEATS - 1, 0, 1'b0, ok_m);
    wait_for(0, ok_m);
    @(posedge clk); #1 bus.weight_done = 1'b1;
    @(posedge clk); #1 bus.weight_done = 1'b0;
    wait_for(1, ok_m);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 bus.act_pe_valid = 1'b1;
    end
    @(posedge clk); #1 bus.act_pe_valid = 1'b0; bus.start = 1'b1; bus.num_tiles = 8'd5;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_done", bus.done, 0);
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_keeps_err_beats", bus.err_beats, 1);
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy || bus.weight_start) busy_seen++;
    end
    check("abort_stays_idle", busy_seen, 0);

    // reset in the middle of tile 1
    pulse_start(2);
    serve_tile(1, N_BEATS - 1, 0, 1'b1, ok_m);
    wait_for(0, ok_m);
    check("pre_rst_err_beats", bus.err_beats, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_busy", bus.busy, 0);
    check("midrun_rst_done", bus.done, 0);
    check("midrun_rst_tile_idx", bus.tile_idx, 0);
    check("midrun_rst_weight_start", bus.weight_start, 0);
    check("midrun_rst_act_start", bus.act_start, 0);
    check("midrun_rst_err_beats", bus.err_beats, 0);
    check("midrun_rst_err_timeout", bus.err_timeout, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_run(2, 0);                         // recovery after reset
    repeat (5) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
